// File: rtl/btn_updown_counter.sv
// Two-button up/down counter: per-button sync, debounce, arming and press FSM feeding a
// wrap/saturate counter with LED image. Define BTN_REPEAT_EN to enable hold-to-auto-repeat.
//
// state    | meaning
// S_IDLE   | released, or not yet armed since reset; waits for a debounced press
// S_DELAY  | (BTN_REPEAT_EN) pressed, counting down to the first auto-repeat
// S_REPEAT | (BTN_REPEAT_EN) pressed, emitting an event every repeat period
// S_HELD   | (no BTN_REPEAT_EN) pressed, waiting for release
module btn_updown_counter #(
    parameter int CLK_HZ          = 27_000_000,
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int SATURATE        = 0,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             at_limit
);

    localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int RD_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int RR_CYC = CLK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int DBW    = $clog2(DB_CYC + 1);
    localparam logic [DBW-1:0]   DB_LOAD  = DBW'(DB_CYC - 1);
    localparam logic             IDLE_LVL = (BTN_ACTIVE_LOW != 0);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    if (WIDTH < 2 || WIDTH > 16 || DB_CYC < 1 || RD_CYC < 1 || RR_CYC < 1) begin : g_bad_param
        $error("btn_updown_counter: invalid parameter set");
    end

`ifdef BTN_REPEAT_EN
    localparam int TMAX = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RD_LOAD = TW'(RD_CYC - 1);
    localparam logic [TW-1:0] RR_LOAD = TW'(RR_CYC - 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DELAY = 2'd1, S_REPEAT = 2'd2} state_t;
`else
    typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;
`endif

    logic [1:0]       btn_raw;
    logic [1:0]       ev;
    logic [WIDTH-1:0] count_nx;

    assign btn_raw = {btn_dn, btn_up};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic           sync_a, sync_b, pressed, db, armed, ev_q, ev_nx;
        logic [1:0]     fill;
        logic [DBW-1:0] db_cnt;
        state_t         state, state_nx;
`ifdef BTN_REPEAT_EN
        logic [TW-1:0]  timer, timer_nx;
`endif

        assign pressed = sync_b ^ IDLE_LVL;

        // Arm only once a valid synchronised sample shows the button released, so a
        // button held through reset cannot produce an event until pressed again.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_a <= IDLE_LVL;
                sync_b <= IDLE_LVL;
                fill   <= 2'b00;
                db     <= 1'b0;
                db_cnt <= DB_LOAD;
                armed  <= 1'b0;
            end else begin
                sync_a <= btn_raw[gi];
                sync_b <= sync_a;
                fill   <= {fill[0], 1'b1};
                if (pressed == db) begin
                    db_cnt <= DB_LOAD;
                end else if (db_cnt == '0) begin
                    db     <= pressed;
                    db_cnt <= DB_LOAD;
                end else begin
                    db_cnt <= db_cnt - 1'b1;
                end
                if (fill[1] && !pressed && !db) armed <= 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_IDLE;
                ev_q  <= 1'b0;
`ifdef BTN_REPEAT_EN
                timer <= '0;
`endif
            end else begin
                state <= state_nx;
                ev_q  <= ev_nx;
`ifdef BTN_REPEAT_EN
                timer <= timer_nx;
`endif
            end
        end

        always_comb begin
            state_nx = state;
            ev_nx    = 1'b0;
`ifdef BTN_REPEAT_EN
            timer_nx = timer;
            case (state)
                S_IDLE: if (armed && db) begin
                    ev_nx    = 1'b1;
                    state_nx = S_DELAY;
                    timer_nx = RD_LOAD;
                end
                S_DELAY: if (!db) begin
                    state_nx = S_IDLE;
                end else if (timer == '0) begin
                    ev_nx    = 1'b1;
                    state_nx = S_REPEAT;
                    timer_nx = RR_LOAD;
                end else begin
                    timer_nx = timer - 1'b1;
                end
                S_REPEAT: if (!db) begin
                    state_nx = S_IDLE;
                end else if (timer == '0) begin
                    ev_nx    = 1'b1;
                    timer_nx = RR_LOAD;
                end else begin
                    timer_nx = timer - 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
`else
            case (state)
                S_IDLE: if (armed && db) begin
                    ev_nx    = 1'b1;
                    state_nx = S_HELD;
                end
                S_HELD: if (!db) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
`endif
        end

        assign ev[gi] = ev_q;
    end

    // Simultaneous up and down events cancel.
    always_comb begin
        count_nx = count;
        if (clr) begin
            count_nx = '0;
        end else if (ev[0] && !ev[1]) begin
            if (!(SATURATE != 0 && count == CNT_MAX)) count_nx = count + 1'b1;
        end else if (ev[1] && !ev[0]) begin
            if (!(SATURATE != 0 && count == '0)) count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            step  <= 1'b0;
        end else begin
            count <= count_nx;
            step  <= (count_nx != count);
        end
    end

    assign led      = (LED_ACTIVE_LOW != 0) ? ~count : count;
    assign at_limit = (count == '0) || (count == CNT_MAX);

endmodule

// File: tb/tb_btn_updown_counter.sv
// Directed bench for btn_updown_counter: one wrap-mode and one saturate-mode instance
// share the same button, clear and reset stimulus.
module tb_btn_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n, btn_up, btn_dn, clr;
    logic [3:0] count_w, led_w, count_s, led_s;
    logic       step_w, step_s, lim_w, lim_s;
    int         tests = 0;
    int         fails = 0;
    int         nstep_w = 0;
    int         nstep_s = 0;
    int         cur, base;
    logic       stp;

    always #5 clk = ~clk;

    btn_updown_counter #(
        .CLK_HZ(1000), .WIDTH(4), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS(3), .SATURATE(0), .BTN_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
        .count(count_w), .led(led_w), .step(step_w), .at_limit(lim_w)
    );

    btn_updown_counter #(
        .CLK_HZ(1000), .WIDTH(4), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS(3), .SATURATE(1), .BTN_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
        .count(count_s), .led(led_s), .step(step_s), .at_limit(lim_s)
    );

    always @(negedge clk) begin
        if (step_w === 1'b1) nstep_w++;
        if (step_s === 1'b1) nstep_s++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === 32'(exp)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press for 9 edges then settle; short enough that no auto-repeat can fire.
    task automatic tap(input logic up, input logic dn);
        btn_up = !up;
        btn_dn = !dn;
        edges(9);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        edges(10);
    endtask

    initial begin
        rst_n = 1'b0; btn_up = 1'b1; btn_dn = 1'b1; clr = 1'b0;
        edges(3);
        check("rst_count", 32'(count_w), 0);
        check("rst_led", 32'(led_w), 15);
        check("rst_limit", 32'(lim_w), 1);
        check("rst_step", 32'(step_w), 0);
        check("rst_count_sat", 32'(count_s), 0);
        rst_n = 1'b1;
        edges(6);

        // Clean press: count moves exactly 8 edges after the press edge.
        btn_up = 1'b0;
        edges(7);
        check("lat_before_count", 32'(count_w), 0);
        check("lat_before_step", 32'(step_w), 0);
        edges(1);
        check("lat_count", 32'(count_w), 1);
        check("lat_step", 32'(step_w), 1);
        check("lat_led", 32'(led_w), 14);
        check("lat_limit", 32'(lim_w), 0);
        check("lat_count_sat", 32'(count_s), 1);
        edges(1);
        check("lat_step_drop", 32'(step_w), 0);
        btn_up = 1'b1;
        edges(10);
        check("press_steps", nstep_w, 1);

        base = nstep_w;
        for (int n = 1; n <= 3; n++) begin
            btn_dn = 1'b0;
            edges(n);
            btn_dn = 1'b1;
            edges(8);
            check("glitch_count", 32'(count_w), 1);
        end
        check("glitch_steps", nstep_w - base, 0);

        clr = 1'b1; edges(1); clr = 1'b0;
        check("clr_count", 32'(count_w), 0);
        check("clr_step", 32'(step_w), 1);
        clr = 1'b1; edges(1); clr = 1'b0;
        check("clr_zero_count", 32'(count_w), 0);
        check("clr_zero_step", 32'(step_w), 0);

        // Hold: increments at +8, then (repeat build) +18 and every 3 to +33.
        cur = 0;
        btn_up = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            edges(1);
`ifdef BTN_REPEAT_EN
            stp = (k == 8) || (k == 18) || (k >= 21 && k <= 33 && (k - 21) % 3 == 0);
`else
            stp = (k == 8);
`endif
            if (stp) cur++;
            check("hold_count", 32'(count_w), cur);
            check("hold_step", 32'(step_w), int'(stp));
            if (k == 27) btn_up = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        check("hold_final", 32'(count_w), 7);
`else
        check("hold_final", 32'(count_w), 1);
`endif
        check("hold_final_sat", 32'(count_s), cur);

        while (cur < 15) begin
            tap(1'b1, 1'b0);
            cur++;
        end
        check("max_count", 32'(count_w), 15);
        check("max_count_sat", 32'(count_s), 15);
        check("max_limit", 32'(lim_w), 1);
        check("max_led", 32'(led_w), 0);

        btn_up = 1'b0;
        edges(8);
        check("wrap_up_count", 32'(count_w), 0);
        check("wrap_up_step", 32'(step_w), 1);
        check("sat_up_count", 32'(count_s), 15);
        check("sat_up_step", 32'(step_s), 0);
        check("sat_up_limit", 32'(lim_s), 1);
        edges(1);
        btn_up = 1'b1;
        edges(10);

        clr = 1'b1; edges(1); clr = 1'b0;
        check("clr2_count", 32'(count_w), 0);
        check("clr2_step", 32'(step_w), 0);
        check("clr2_count_sat", 32'(count_s), 0);
        check("clr2_step_sat", 32'(step_s), 1);

        btn_dn = 1'b0;
        edges(8);
        check("wrap_dn_count", 32'(count_w), 15);
        check("wrap_dn_step", 32'(step_w), 1);
        check("sat_dn_count", 32'(count_s), 0);
        check("sat_dn_step", 32'(step_s), 0);
        edges(1);
        btn_dn = 1'b1;
        edges(10);

        clr = 1'b1; edges(1); clr = 1'b0;
        repeat (5) tap(1'b1, 1'b0);
        check("five_count", 32'(count_w), 5);
        check("five_count_sat", 32'(count_s), 5);

        base = nstep_w;
        btn_up = 1'b0; btn_dn = 1'b0;
        edges(8);
        check("both_count", 32'(count_w), 5);
        edges(1);
        btn_up = 1'b1; btn_dn = 1'b1;
        edges(10);
        check("both_count_after", 32'(count_w), 5);
        check("both_steps", nstep_w - base, 0);

        // Clear lands on the same edge the up event reaches the counter.
        btn_up = 1'b0;
        edges(7);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        check("clr_up_count", 32'(count_w), 0);
        check("clr_up_step", 32'(step_w), 1);
        check("clr_up_count_sat", 32'(count_s), 0);
        edges(1);
        btn_up = 1'b1;
        edges(10);
        check("clr_up_after", 32'(count_w), 0);

        tap(1'b1, 1'b0);
        check("pre_reset_count", 32'(count_w), 1);
        rst_n = 1'b0;
        btn_up = 1'b0;
        edges(3);
        check("held_rst_count", 32'(count_w), 0);
        rst_n = 1'b1;
        base = nstep_w;
        edges(20);
        check("held_count", 32'(count_w), 0);
        check("held_steps", nstep_w - base, 0);
        btn_up = 1'b1;
        edges(10);
        check("held_release_count", 32'(count_w), 0);
        tap(1'b1, 1'b0);
        check("held_repress_count", 32'(count_w), 1);
        check("held_repress_count_sat", 32'(count_s), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
